// File: rtl/top_if.sv
// top_if: 6502 CPU bus between the processor side and the mapache64 glue block
//   cpu_clk_enable   - one-cycle bus strobe (CPU side)
//   cpu_address      - 16-bit address (CPU side)
//   data_in          - write data (CPU side)
//   write_enable_B   - 0 = write, 1 = read (CPU side)
//   data_out         - read data for FPGA-owned I/O (glue side)
//   fpga_data_enable - data_out drives the bus (glue side)
//   SELECT_ram_B, ram_OE_B, SELECT_rom_B - active-low memory selects (glue side)
interface top_if;
    logic        cpu_clk_enable;
    logic [15:0] cpu_address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        fpga_data_enable;
    logic        write_enable_B;
    logic        SELECT_ram_B;
    logic        ram_OE_B;
    logic        SELECT_rom_B;
    modport master (
        output cpu_clk_enable, cpu_address, data_in, write_enable_B,
        input  data_out, fpga_data_enable, SELECT_ram_B, ram_OE_B, SELECT_rom_B
    );
    modport slave (
        input  cpu_clk_enable, cpu_address, data_in, write_enable_B,
        output data_out, fpga_data_enable, SELECT_ram_B, ram_OE_B, SELECT_rom_B
    );
endinterface

// File: rtl/top.sv
// top: mapache64 glue - address decode, I/O reads, VGA timing, vblank IRQ, NES pad polling
//   clk_12_5875 / rst         - pixel clock, async active-high reset
//   bus (top_if.slave)        - CPU bus, memory selects and FPGA read data
//   vblank_irq_B              - active-low vblank interrupt
//   r, g, b, hsync, vsync     - registered VGA outputs (syncs active-low)
//   controller_*              - tick in, shift strobe / latch out, serial data in,
//                               assembled button bytes out
module top (
    input  logic       clk_12_5875,
    input  logic       rst,
    top_if.slave       bus,
    output logic       vblank_irq_B,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hsync,
    output logic       vsync,
    input  logic       controller_clk_in_enable,
    output logic       controller_clk_out_enable,
    output logic       controller_latch,
    input  logic       controller_1_data_in_B,
    input  logic       controller_2_data_in_B,
    output logic [7:0] controller_1_buttons_out,
    output logic [7:0] controller_2_buttons_out
);
    // IDLE only exists between reset and the first tick; B7..B0 are 2..9
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LATCH = 4'd1;
    localparam logic [3:0] S_B0    = 4'd9;

    logic [8:0] h;
    logic [9:0] v;
    logic [5:0] bg;
    logic [3:0] state, state_nx;
    logic [6:0] sh_1, sh_2;
    logic       in_ram, in_io, in_rom, vblank, h_end, cpu_rd, cpu_wr, unused_data;

    assign in_ram = bus.cpu_address < 16'h3000;
    assign in_io  = bus.cpu_address[15:12] == 4'h7;
    assign in_rom = !in_ram && !in_io && bus.cpu_address[15:12] != 4'h3;
    assign vblank = v >= 10'd480;
    assign cpu_rd = bus.cpu_clk_enable && bus.write_enable_B;
    assign cpu_wr = bus.cpu_clk_enable && !bus.write_enable_B;
    assign unused_data = ^bus.data_in[7:6];

    assign bus.SELECT_ram_B     = !in_ram;
    assign bus.ram_OE_B         = !(in_ram && bus.write_enable_B);
    assign bus.SELECT_rom_B     = !in_rom;
    assign bus.fpga_data_enable = bus.write_enable_B && in_io;
    assign bus.data_out = bus.cpu_address == 16'h7000 ? {7'd0, vblank} :
                          bus.cpu_address == 16'h7002 ? controller_1_buttons_out :
                          bus.cpu_address == 16'h7003 ? controller_2_buttons_out : 8'h00;

    assign h_end = h == 9'd399;

    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_end ? 9'd0 : h + 9'd1;
            if (h_end) v <= v == 10'd524 ? 10'd0 : v + 10'd1;
        end
    end

    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            bg    <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            {r, g, b} <= '0;
        end else begin
            if (cpu_wr && bus.cpu_address == 16'h3EC0) bg <= bus.data_in[5:0];
            hsync <= h < 9'd328 || h > 9'd375;
            vsync <= v != 10'd490 && v != 10'd491;
            {r, g, b} <= (h < 9'd320 && v < 10'd480) ? bg : 6'd0;
        end
    end

    // setting at the start of vblank takes priority over a coinciding status read
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) vblank_irq_B <= 1'b1;
        else if (h == 9'd0 && v == 10'd480) vblank_irq_B <= 1'b0;
        else if ((cpu_rd && bus.cpu_address == 16'h7000) || v == 10'd0) vblank_irq_B <= 1'b1;
    end

    assign state_nx = (state == S_IDLE || state == S_B0) ? S_LATCH : state + 4'd1;
    assign controller_latch = state == S_LATCH;

    // each tick entering a bit state samples one bit MSB-first and pulses the pad clock;
    // the B0 tick publishes both completed bytes at once
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sh_1  <= '0;
            sh_2  <= '0;
            controller_clk_out_enable <= 1'b0;
            controller_1_buttons_out  <= '0;
            controller_2_buttons_out  <= '0;
        end else begin
            controller_clk_out_enable <= controller_clk_in_enable && state_nx != S_LATCH;
            if (controller_clk_in_enable) begin
                state <= state_nx;
                if (state_nx != S_LATCH) begin
                    sh_1 <= {sh_1[5:0], ~controller_1_data_in_B};
                    sh_2 <= {sh_2[5:0], ~controller_2_data_in_B};
                end
                if (state_nx == S_B0) begin
                    controller_1_buttons_out <= {sh_1, ~controller_1_data_in_B};
                    controller_2_buttons_out <= {sh_2, ~controller_2_data_in_B};
                end
            end
        end
    end
endmodule

// File: tb/tb_top.sv
// tb_top: randomized self-checking bench for the mapache64 glue block
module tb_top;
    logic clk_12_5875 = 1'b0;
    logic rst = 1'b1;
    always #5 clk_12_5875 = ~clk_12_5875;

    top_if bus();
    logic       vblank_irq_B, hsync, vsync, tick_en, clk_out, latch, d1, d2;
    logic [1:0] r, g, b;
    logic [7:0] btn_o1, btn_o2;

    top dut (
        .clk_12_5875(clk_12_5875), .rst(rst), .bus(bus),
        .vblank_irq_B(vblank_irq_B), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
        .controller_clk_in_enable(tick_en), .controller_clk_out_enable(clk_out),
        .controller_latch(latch),
        .controller_1_data_in_B(d1), .controller_2_data_in_B(d2),
        .controller_1_buttons_out(btn_o1), .controller_2_buttons_out(btn_o2)
    );

    int checks = 0, failures = 0;

    // video/irq reference: frame position is just elapsed clocks (plus a jump offset)
    int n, ofs = 0, p_m, h_m, v_m;
    int hs_cnt = 0, vs_cnt = 0;
    logic [7:0] exp_vid;
    logic       exp_irq;
    logic [5:0] bg_m;

    always @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            n <= 0;
            bg_m <= '0;
            exp_vid <= 8'hC0;
            exp_irq <= 1'b1;
        end else begin
            p_m = (n + ofs) % 210000;
            h_m = p_m % 400;
            v_m = p_m / 400;
            exp_vid <= {h_m < 328 || h_m > 375, v_m != 490 && v_m != 491,
                        (h_m < 320 && v_m < 480) ? bg_m : 6'd0};
            if (h_m == 0 && v_m == 480) exp_irq <= 1'b0;
            else if ((bus.cpu_clk_enable && bus.write_enable_B && bus.cpu_address == 16'h7000) || v_m == 0)
                exp_irq <= 1'b1;
            if (bus.cpu_clk_enable && !bus.write_enable_B && bus.cpu_address == 16'h3EC0)
                bg_m <= bus.data_in[5:0];
            n <= n + 1;
        end
    end

    always @(posedge clk_12_5875) begin
        if (!hsync) hs_cnt++;
        if (!vsync) vs_cnt++;
    end

    // NES pad model: latch reloads to the MSB, each shift strobe advances one bit
    logic [7:0] pad1 = 8'h00, pad2 = 8'h00;
    logic [2:0] idx;
    always @(posedge clk_12_5875 or posedge rst) begin
        if (rst || latch) idx <= 3'd7;
        else if (clk_out && idx != 3'd0) idx <= idx - 3'd1;
    end
    assign d1 = ~pad1[idx];
    assign d2 = ~pad2[idx];

    logic [15:0] fixed_addr [12] = '{16'h4000, 16'h6FFF, 16'h8000, 16'h9000, 16'hFFFA, 16'hFFFF,
                                     16'h1000, 16'h2FFF, 16'h3000, 16'h3FFF, 16'h7000, 16'h7FFF};

    task step;
        @(posedge clk_12_5875);
        #1;
    endtask

    task cpu_read(input logic [15:0] a, output logic [7:0] d, output logic fe);
        bus.cpu_address = a;
        bus.write_enable_B = 1'b1;
        bus.cpu_clk_enable = 1'b1;
        #1;
        d = bus.data_out;
        fe = bus.fpga_data_enable;
        step;
        bus.cpu_clk_enable = 1'b0;
    endtask

    task cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_address = a;
        bus.data_in = d;
        bus.write_enable_B = 1'b0;
        bus.cpu_clk_enable = 1'b1;
        step;
        bus.cpu_clk_enable = 1'b0;
        bus.write_enable_B = 1'b1;
    endtask

    task tick_pulse;
        tick_en = 1'b1;
        step;
        tick_en = 1'b0;
    endtask

    task ticks(input int k);
        repeat (k) begin
            tick_pulse;
            repeat ($urandom_range(1, 3)) step;
        end
    endtask

    task automatic run_video(input int cyc);
        bit bad = 1'b0;
        for (int i = 0; i < cyc && !bad; i++) begin
            step;
            checks++;
            if ({hsync, vsync, r, g, b, vblank_irq_B} !== {exp_vid, exp_irq}) begin
                failures++;
                bad = 1'b1;
                $display("FAIL video pos=%0d got=%b want=%b", (n + ofs) % 210000,
                         {hsync, vsync, r, g, b, vblank_irq_B}, {exp_vid, exp_irq});
            end
        end
    endtask

    task automatic jump_to_479;
        int cur;
        if ((n + ofs) % 400 == 399) step;
        cur = (n + ofs) % 210000;
        force dut.v = 10'd479;
        ofs = ofs + 479 * 400 + cur % 400 - cur;
        step;
        release dut.v;
    endtask

    task test_reset;
        rst = 1'b1;
        repeat (2) step;
        checks += 6;
        if (vblank_irq_B !== 1'b1) begin failures++; $display("FAIL reset_irq got=%b want=1", vblank_irq_B); end
        if ({hsync, vsync} !== 2'b11) begin failures++; $display("FAIL reset_sync got=%b want=11", {hsync, vsync}); end
        if ({r, g, b} !== 6'd0) begin failures++; $display("FAIL reset_rgb got=%h want=00", {r, g, b}); end
        if ({latch, clk_out} !== 2'b00) begin failures++; $display("FAIL reset_ctl got=%b want=00", {latch, clk_out}); end
        if (btn_o1 !== 8'h00) begin failures++; $display("FAIL reset_btn1 got=%h want=00", btn_o1); end
        if (btn_o2 !== 8'h00) begin failures++; $display("FAIL reset_btn2 got=%h want=00", btn_o2); end
        rst = 1'b0;
    endtask

    task automatic test_decode;
        logic [15:0] a;
        logic ram, rom, io;
        for (int i = 0; i < 40; i++) begin
            a = i < 12 ? fixed_addr[i] : 16'($urandom);
            ram = a < 16'h3000;
            io = a >= 16'h7000 && a < 16'h8000;
            rom = (a >= 16'h4000 && a < 16'h7000) || a >= 16'h8000;
            for (int w = 0; w < 2; w++) begin
                bus.cpu_address = a;
                bus.write_enable_B = w[0];
                #1;
                checks++;
                if ({bus.SELECT_ram_B, bus.ram_OE_B, bus.SELECT_rom_B, bus.fpga_data_enable} !==
                    {!ram, !(ram && w[0]), !rom, w[0] && io}) begin
                    failures++;
                    $display("FAIL decode addr=%h we_B=%0d got=%b want=%b", a, w,
                             {bus.SELECT_ram_B, bus.ram_OE_B, bus.SELECT_rom_B, bus.fpga_data_enable},
                             {!ram, !(ram && w[0]), !rom, w[0] && io});
                end
                if (w == 1 && io && a != 16'h7002 && a != 16'h7003) begin
                    checks++;
                    if (bus.data_out !== {7'd0, ((n + ofs) % 210000) / 400 >= 480}) begin
                        failures++;
                        $display("FAIL io_read addr=%h got=%h want=%h", a, bus.data_out,
                                 {7'd0, ((n + ofs) % 210000) / 400 >= 480});
                    end
                end
                step;
            end
        end
        bus.write_enable_B = 1'b1;
    endtask

    task automatic test_controller;
        logic [7:0] rd, prev1, prev2;
        logic fe;
        rst = 1'b1;
        step;
        rst = 1'b0;
        pad1 = 8'h89;
        pad2 = 8'h26;
        tick_pulse;
        checks++;
        if ({latch, clk_out} !== 2'b10) begin failures++; $display("FAIL ctl_latch got=%b want=10", {latch, clk_out}); end
        repeat (3) step;
        tick_pulse;
        checks++;
        if ({latch, clk_out} !== 2'b01) begin failures++; $display("FAIL ctl_pulse got=%b want=01", {latch, clk_out}); end
        step;
        checks++;
        if (clk_out !== 1'b0) begin failures++; $display("FAIL ctl_pulse_width got=%b want=0", clk_out); end
        step;
        ticks(7);
        checks += 2;
        if (btn_o1 !== 8'h89) begin failures++; $display("FAIL ctl_btn1 got=%h want=89", btn_o1); end
        if (btn_o2 !== 8'h26) begin failures++; $display("FAIL ctl_btn2 got=%h want=26", btn_o2); end
        cpu_read(16'h7002, rd, fe);
        checks++;
        if ({rd, fe} !== {8'h89, 1'b1}) begin failures++; $display("FAIL rd_7002 got=%h/%b want=89/1", rd, fe); end
        cpu_read(16'h7003, rd, fe);
        checks++;
        if ({rd, fe} !== {8'h26, 1'b1}) begin failures++; $display("FAIL rd_7003 got=%h/%b want=26/1", rd, fe); end
        prev1 = pad1;
        prev2 = pad2;
        pad1 = 8'($urandom);
        pad2 = 8'($urandom);
        ticks(5);
        cpu_read(16'h7002, rd, fe);
        checks++;
        if (rd !== prev1) begin failures++; $display("FAIL mid_poll_7002 got=%h want=%h", rd, prev1); end
        cpu_read(16'h7003, rd, fe);
        checks++;
        if (rd !== prev2) begin failures++; $display("FAIL mid_poll_7003 got=%h want=%h", rd, prev2); end
        ticks(4);
        checks++;
        if ({btn_o1, btn_o2} !== {pad1, pad2}) begin
            failures++;
            $display("FAIL ctl_new got=%h want=%h", {btn_o1, btn_o2}, {pad1, pad2});
        end
        ticks(4);
        rst = 1'b1;
        #1;
        checks++;
        if ({btn_o1, btn_o2, latch, clk_out} !== 18'd0) begin
            failures++;
            $display("FAIL ctl_reset got=%h want=0", {btn_o1, btn_o2, latch, clk_out});
        end
        step;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pad1 = 8'($urandom);
            pad2 = 8'($urandom);
            ticks(9);
            checks++;
            if ({btn_o1, btn_o2} !== {pad1, pad2}) begin
                failures++;
                $display("FAIL ctl_rand%0d got=%h want=%h", i, {btn_o1, btn_o2}, {pad1, pad2});
            end
        end
    endtask

    task automatic test_frame;
        int hs0, vs0, rem;
        logic [7:0] rd;
        logic fe;
        jump_to_479;
        hs0 = hs_cnt;
        run_video(400);
        checks++;
        if (hs_cnt - hs0 != 48) begin failures++; $display("FAIL hsync_low got=%0d want=48", hs_cnt - hs0); end
        run_video(400);
        checks++;
        if (vblank_irq_B !== 1'b0) begin failures++; $display("FAIL irq_set got=%b want=0", vblank_irq_B); end
        cpu_read(16'h7000, rd, fe);
        checks += 2;
        if ({rd, fe} !== {8'h01, 1'b1}) begin failures++; $display("FAIL status_read got=%h/%b want=01/1", rd, fe); end
        if (vblank_irq_B !== 1'b1) begin failures++; $display("FAIL irq_clear_read got=%b want=1", vblank_irq_B); end
        vs0 = vs_cnt;
        for (int i = 0; i < 6000 && vsync !== 1'b0; i++) run_video(1);
        checks++;
        if (vsync !== 1'b0) begin failures++; $display("FAIL vsync_fall timeout got=%b want=0", vsync); end
        cpu_write(16'h3EC0, 8'h15);
        cpu_write(16'h3700, 8'($urandom));
        cpu_write(16'h3F00, 8'($urandom));
        cpu_write(16'h3B01, 8'($urandom));
        rem = 210000 - (n + ofs) % 210000 + 10;
        run_video(rem);
        checks += 2;
        if (vs_cnt - vs0 != 800) begin failures++; $display("FAIL vsync_low got=%0d want=800", vs_cnt - vs0); end
        if ({r, g, b} !== 6'h15) begin failures++; $display("FAIL bg_visible got=%h want=15", {r, g, b}); end
    endtask

    task automatic test_bg_random;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            cpu_write(i[0] ? 16'h3EC0 : 16'h3000 + 16'($urandom_range(0, 4095)), d);
            run_video(40);
        end
    endtask

    task automatic test_irq_auto;
        int rem;
        jump_to_479;
        run_video(800);
        checks++;
        if (vblank_irq_B !== 1'b0) begin failures++; $display("FAIL irq_set2 got=%b want=0", vblank_irq_B); end
        rem = 210000 - (n + ofs) % 210000 + 3;
        run_video(rem);
        checks++;
        if (vblank_irq_B !== 1'b1) begin failures++; $display("FAIL irq_clear_v0 got=%b want=1", vblank_irq_B); end
    endtask

    initial begin
        bus.cpu_clk_enable = 1'b0;
        bus.cpu_address = 16'h0000;
        bus.data_in = 8'h00;
        bus.write_enable_B = 1'b1;
        tick_en = 1'b0;
        test_reset;
        test_decode;
        test_controller;
        test_frame;
        test_bg_random;
        test_irq_auto;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
